// File: rtl/snn_image_feeder.sv
// -----------------------------------------------------------------------------
// snn_image_feeder
//
// Upstream feeder for the train_test_classify core. It collects one image as a
// byte-per-pixel stream, packs four bytes per 32-bit word (first byte in the
// MSBs) and then replays the buffered image to the core. The image is presented
// rep_count times. Each presentation is a start_main pulse, then M/4 back-to-back
// valid_image words, then a wait for valid_all, then GAP idle cycles.
//
// Parameters
//   M    pixels per image (multiple of 4, at least 8)
//   GAP  idle cycles after valid_all before the next start_main (at least 1)
//   CW   width of the repeat and presentation counters
//
// Ports
//   clk                  clock, all state on the rising edge
//   rst                  asynchronous reset, active low
//   pix_in / pix_valid   host pixel byte and its valid
//   pix_ready            feeder accepts a byte (only while loading)
//   rep_count            presentations per image, 0 is treated as 1
//   mode_in / label_in   mode and label for the image being loaded
//   train_test_classify  latched mode presented to the core
//   test_label           latched label presented to the core
//   start_main           one-cycle start pulse to the core
//   image_in             packed pixel word to the core (0 when not valid)
//   valid_image          image_in valid
//   valid_all            core finished the current presentation
//   busy                 high whenever the feeder is not loading
//   pres_done            presentations completed for the current image
//   img_done             one-cycle pulse when the final gap ends
// -----------------------------------------------------------------------------
module snn_image_feeder #(
    parameter int M   = 784,
    parameter int GAP = 4,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [CW-1:0] rep_count,
    input  logic [1:0]    mode_in,
    input  logic [7:0]    label_in,
    output logic [1:0]    train_test_classify,
    output logic [7:0]    test_label,
    output logic          start_main,
    output logic [31:0]   image_in,
    output logic          valid_image,
    input  logic          valid_all,
    output logic          busy,
    output logic [CW-1:0] pres_done,
    output logic          img_done
);

    localparam int NW = M / 4;
    localparam int BW = $clog2(M);
    localparam int WW = $clog2(NW);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_STREAM,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [BW-1:0]   bcnt;       // bytes accepted for the image being loaded
    logic [WW-1:0]   widx;       // word being streamed
    logic [GW-1:0]   gcnt;       // idle cycles spent in the gap
    logic [CW-1:0]   rep_lat;    // latched repeat count, never 0
    logic [23:0]     pack;       // first three bytes of the word being assembled
    logic [31:0]     buf_mem [NW];

    logic            in_load;
    logic            byte_acc;
    logic            last_byte;
    logic            last_word;
    logic            gap_end;
    logic            more_pres;

    // Decodes are taken from the state register, not from pix_ready, so the
    // output process below has no path back into itself.
    assign in_load   = (state == S_LOAD);
    assign byte_acc  = in_load && pix_valid;
    assign last_byte = byte_acc && (bcnt == BW'(M - 1));
    assign last_word = (widx == WW'(NW - 1));
    assign gap_end   = (gcnt == GW'(GAP - 1));
    // pres_done has already been advanced for the presentation just finished.
    assign more_pres = (pres_done < rep_lat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pix_ready   = 1'b0;
        start_main  = 1'b0;
        valid_image = 1'b0;
        image_in    = '0;
        busy        = 1'b1;
        unique case (state)
            S_LOAD: begin
                pix_ready = 1'b1;
                busy      = 1'b0;
                if (last_byte) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                start_main = 1'b1;
                state_nxt  = S_STREAM;
            end
            S_STREAM: begin
                valid_image = 1'b1;
                image_in    = buf_mem[widx];
                if (last_word) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (valid_all) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nxt = more_pres ? S_START : S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // Control counters and the values latched per image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt                <= '0;
            widx                <= '0;
            gcnt                <= '0;
            rep_lat             <= CW'(1);
            pres_done           <= '0;
            train_test_classify <= '0;
            test_label          <= '0;
            img_done            <= 1'b0;
        end else begin
            img_done <= (state == S_GAP) && gap_end && !more_pres;

            if (byte_acc) begin
                bcnt <= last_byte ? '0 : bcnt + BW'(1);
            end

            if (last_byte) begin
                rep_lat             <= (rep_count == '0) ? CW'(1) : rep_count;
                train_test_classify <= mode_in;
                test_label          <= label_in;
                pres_done           <= '0;
            end

            if (state == S_START) begin
                widx <= '0;
            end else if (state == S_STREAM) begin
                widx <= last_word ? '0 : widx + WW'(1);
            end

            if (state == S_WAIT && valid_all) begin
                pres_done <= pres_done + CW'(1);
                gcnt      <= '0;
            end else if (state == S_GAP) begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

    // Image buffer: bytes shift into pack until the fourth byte of a group
    // arrives, then the whole word is written. Contents are not reset.
    always_ff @(posedge clk) begin
        if (byte_acc) begin
            pack <= {pack[15:0], pix_in};
            if (bcnt[1:0] == 2'd3) begin
                buf_mem[bcnt[BW-1:2]] <= {pack, pix_in};
            end
        end
    end

endmodule

// File: tb/tb_snn_image_feeder.sv
`timescale 1ns/1ps
module tb_snn_image_feeder;

    localparam int M   = 784;
    localparam int GAP = 4;
    localparam int CW  = 16;
    localparam int NW  = M / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] rep_count;
    logic [1:0]    mode_in;
    logic [7:0]    label_in;
    logic [1:0]    train_test_classify;
    logic [7:0]    test_label;
    logic          start_main;
    logic [31:0]   image_in;
    logic          valid_image;
    logic          valid_all;
    logic          busy;
    logic [CW-1:0] pres_done;
    logic          img_done;

    snn_image_feeder #(.M(M), .GAP(GAP), .CW(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pix_in              (pix_in),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .rep_count           (rep_count),
        .mode_in             (mode_in),
        .label_in            (label_in),
        .train_test_classify (train_test_classify),
        .test_label          (test_label),
        .start_main          (start_main),
        .image_in            (image_in),
        .valid_image         (valid_image),
        .valid_all           (valid_all),
        .busy                (busy),
        .pres_done           (pres_done),
        .img_done            (img_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: one record per expected presentation plus the words it
    // must carry. Filled by the stimulus, drained by the monitor.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] label;
        int         pres_no;
        bit         last;
    } pres_t;

    pres_t       pres_q[$];
    logic [31:0] word_q[$];

    int    phase  = 0;   // 0 idle, 1 streaming, 2 awaiting valid_all, 3 in gap
    int    widx   = 0;
    int    st_cyc = 0;
    int    va_cyc = 0;
    pres_t cur;

    always @(negedge clk) begin
        if (!rst) begin
            phase = 0;
            widx  = 0;
            pres_q.delete();
            word_q.delete();
        end else begin
            if (phase == 3 && cyc == va_cyc + 1)
                chk("pres_done_after_valid_all", pres_done, cur.pres_no);
            if (phase == 3 && cyc == va_cyc + GAP + 1) begin
                chk("img_done_at_gap_end", img_done, cur.last);
                chk("restart_at_gap_end", start_main, !cur.last);
                if (cur.last) chk("pix_ready_with_img_done", pix_ready, 1);
                phase = 0;
            end else if (img_done) begin
                chk("img_done_stray", img_done, 0);
            end

            if (start_main) begin
                chk("start_while_active", phase, 0);
                if (pres_q.size() == 0) begin
                    chk("start_unexpected", start_main, 0);
                end else begin
                    cur = pres_q.pop_front();
                    chk("mode", train_test_classify, cur.mode);
                    chk("label", test_label, cur.label);
                    chk("pres_done_at_start", pres_done, cur.pres_no - 1);
                    st_cyc = cyc;
                    widx   = 0;
                    phase  = 1;
                end
            end else if (valid_image) begin
                chk("word_outside_stream", phase, 1);
                chk("word_timing", cyc, st_cyc + 1 + widx);
                if (word_q.size() == 0)
                    chk("word_unexpected", valid_image, 0);
                else
                    chk($sformatf("word%0d", widx), image_in, word_q.pop_front());
                widx++;
                if (widx == NW) phase = 2;
            end else begin
                if (phase == 1) begin
                    chk("stream_bubble", valid_image, 1);
                    phase = 2;
                end
                chk("image_in_idle", image_in, 0);
                if (phase == 2 && valid_all) begin
                    va_cyc = cyc;
                    phase  = 3;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Core model: valid_all pulses va_delay cycles after the last word;
    // optionally also driven high during the stream itself.
    // ------------------------------------------------------------------
    int va_delay = 10;
    bit va_force = 0;

    initial begin
        int wc;
        int cd;
        wc = 0;
        cd = -1;
        valid_all = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                wc = 0;
                cd = -1;
                valid_all = 1'b0;
            end else begin
                valid_all = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        valid_all = 1'b1;
                        cd = -1;
                    end
                end
                if (valid_image) begin
                    if (va_force) valid_all = 1'b1;
                    wc++;
                    if (wc == NW) begin
                        wc = 0;
                        cd = va_delay;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [7:0] img [M];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic make_img(input int kind);
        for (int i = 0; i < M; i++)
            img[i] = (kind == 0) ? 8'(i % 16) : 8'($urandom);
    endtask

    task automatic expect_img(input int reps, input logic [1:0] mode, input logic [7:0] label);
        int n;
        pres_t p;
        n = (reps == 0) ? 1 : reps;
        for (int r = 0; r < n; r++) begin
            p.mode    = mode;
            p.label   = label;
            p.pres_no = r + 1;
            p.last    = (r == n - 1);
            pres_q.push_back(p);
            for (int w = 0; w < NW; w++)
                word_q.push_back({img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});
        end
    endtask

    task automatic drive_bytes(input int first, input int n, input int gap_pct);
        int tmo;
        for (int i = first; i < first + n; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom);
                step();
            end
            pix_valid = 1'b1;
            pix_in    = img[i];
            tmo = 0;
            while (!pix_ready && tmo < 2000) begin
                step();
                tmo++;
            end
            if (tmo >= 2000) begin
                chk("pix_ready_timeout", pix_ready, 1);
                break;
            end
            step();
        end
        pix_valid = 1'b0;
    endtask

    task automatic load_image(input int kind, input int gap_pct, input int reps,
                              input logic [1:0] mode, input logic [7:0] label);
        make_img(kind);
        rep_count = CW'(reps);
        mode_in   = mode;
        label_in  = label;
        expect_img(reps, mode, label);
        drive_bytes(0, M, gap_pct);
        chk("start_latency", start_main, 1);
        chk("busy_after_load", busy, 1);
        chk("pix_ready_after_load", pix_ready, 0);
        // Later changes must not affect the image just latched.
        rep_count = CW'($urandom);
        mode_in   = 2'($urandom);
        label_in  = 8'($urandom);
    endtask

    task automatic wait_img();
        int t;
        t = 0;
        while (!img_done && t < 20000) begin
            step();
            t++;
        end
        if (t >= 20000) chk("img_done_timeout", img_done, 1);
        chk("pix_ready_idle", pix_ready, 1);
        chk("busy_idle", busy, 0);
        step();
        step();
    endtask

    initial begin
        int t;
        pix_in    = '0;
        pix_valid = 1'b0;
        rep_count = CW'(1);
        mode_in   = '0;
        label_in  = '0;

        #1;
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_start_main", start_main, 0);
        chk("rst_valid_image", valid_image, 0);
        chk("rst_image_in", image_in, 0);
        chk("rst_mode", train_test_classify, 0);
        chk("rst_label", test_label, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pres_done", pres_done, 0);
        chk("rst_img_done", img_done, 0);
        step();
        step();
        rst = 1'b1;
        step();

        // Sequential bytes, single presentation.
        va_delay = 10;
        load_image(0, 0, 1, 2'd1, 8'd7);
        wait_img();

        // Three presentations; host keeps offering bytes while busy.
        load_image(0, 0, 3, 2'd2, 8'h55);
        for (int k = 0; k < 300; k++) begin
            pix_valid = 1'b1;
            pix_in    = 8'($urandom);
            if (k % 25 == 0) chk("pix_ready_while_busy", pix_ready, 0);
            step();
        end
        pix_valid = 1'b0;
        wait_img();

        // rep_count of 0 means one presentation.
        va_delay = 3;
        load_image(1, 0, 0, 2'd3, 8'hA5);
        wait_img();

        // valid_all high through the stream must not end the presentation.
        va_force = 1;
        va_delay = 15;
        load_image(1, 0, 2, 2'd0, 8'h3C);
        wait_img();
        va_force = 0;

        // Random stalls during load, shortest wait.
        va_delay = 1;
        load_image(0, 50, 1, 2'd1, 8'd9);
        wait_img();

        // Reset in the middle of the stream.
        va_delay = 8;
        load_image(1, 0, 1, 2'd2, 8'h11);
        t = 0;
        while (!(phase == 1 && widx >= 100) && t < 1000) begin
            step();
            t++;
        end
        if (t >= 1000) chk("reach_word100_timeout", phase, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid_image", valid_image, 0);
        chk("mid_rst_start_main", start_main, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_image_in", image_in, 0);
        chk("mid_rst_pix_ready", pix_ready, 1);
        chk("mid_rst_pres_done", pres_done, 0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 40; k++) step();

        // Partial load, then reset: those bytes must be discarded.
        make_img(1);
        drive_bytes(0, 500, 0);
        for (int k = 0; k < 20; k++) step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        load_image(1, 0, 1, 2'd3, 8'h42);
        wait_img();

        // A few fully random images.
        for (int n = 0; n < 3; n++) begin
            va_delay = int'($urandom_range(20, 1));
            va_force = bit'($urandom_range(1));
            load_image(1, 30, int'($urandom_range(2, 1)), 2'($urandom), 8'($urandom));
            wait_img();
        end
        va_force = 0;

        chk("queue_pres_empty", pres_q.size(), 0);
        chk("queue_word_empty", word_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
